// File: rtl/mcp23s17_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mcp23s17_poll_sequencer
// Brief    : MCP23S17 joystick expander command sequencer (config writes, then
//            GPIOA/GPIOB reads on INTA or periodic timer) over a txn/rsp engine.
// Revision : 1.0
// ============================================================================
module mcp23s17_poll_sequencer #(
  parameter logic [2:0] HW_ADDR     = 3'b000,
  parameter int         STARTUP_CYC = 2800,
  parameter int         POLL_CYC    = 280000,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta,
  output logic       txn_valid,
  input  logic       txn_ready,
  output logic [7:0] txn_opcode,
  output logic [7:0] txn_reg,
  output logic [7:0] txn_wdata,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  output logic       ready,
  output logic [7:0] joya,
  output logic [7:0] joyb,
  output logic [7:0] err_count
);

  localparam int SW = (STARTUP_CYC > 2) ? $clog2(STARTUP_CYC) : 1;
  localparam int PW = (POLL_CYC    > 2) ? $clog2(POLL_CYC)    : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SW-1:0] ST_LAST   = SW'(STARTUP_CYC - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    CFG_LAST  = 3'd6;

  typedef enum logic [2:0] {
    ST_STARTUP   = 3'd0,
    ST_CFG_REQ   = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_POLL_IDLE = 3'd3,
    ST_RDA_REQ   = 3'd4,
    ST_RDA_WAIT  = 3'd5,
    ST_RDB_REQ   = 3'd6,
    ST_RDB_WAIT  = 3'd7
  } state_t;

  state_t        state, state_n;
  logic [2:0]    idx, idx_n;
  logic [SW-1:0] st_cnt, st_cnt_n;
  logic [PW-1:0] poll_cnt, poll_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          ready_n;
  logic [7:0]    joya_n, joyb_n, err_n;
  logic          inta_meta, inta_sync;
  logic [7:0]    cfg_reg, cfg_data;
  logic          accept, in_wait, timeout;

  always_comb begin
    cfg_reg  = 8'h00;
    cfg_data = 8'hFF;
    case (idx)
      3'd0:    begin cfg_reg = 8'h0A; cfg_data = 8'h40; end  // IOCON.MIRROR
      3'd1:    cfg_reg = 8'h00;
      3'd2:    cfg_reg = 8'h01;
      3'd3:    cfg_reg = 8'h0C;
      3'd4:    cfg_reg = 8'h0D;
      3'd5:    cfg_reg = 8'h04;
      3'd6:    cfg_reg = 8'h05;
      default: begin cfg_reg = 8'h00; cfg_data = 8'h00; end
    endcase
  end

  always_comb begin
    txn_valid  = 1'b0;
    txn_opcode = 8'h00;
    txn_reg    = 8'h00;
    txn_wdata  = 8'h00;
    case (state)
      ST_CFG_REQ: begin
        txn_valid  = 1'b1;
        txn_opcode = {4'b0100, HW_ADDR, 1'b0};
        txn_reg    = cfg_reg;
        txn_wdata  = cfg_data;
      end
      ST_RDA_REQ: begin
        txn_valid  = 1'b1;
        txn_opcode = {4'b0100, HW_ADDR, 1'b1};
        txn_reg    = 8'h12;
      end
      ST_RDB_REQ: begin
        txn_valid  = 1'b1;
        txn_opcode = {4'b0100, HW_ADDR, 1'b1};
        txn_reg    = 8'h13;
      end
      default: ;
    endcase
  end

  assign accept  = txn_valid && txn_ready;
  assign in_wait = (state == ST_CFG_WAIT) || (state == ST_RDA_WAIT) || (state == ST_RDB_WAIT);
  // A response in the final timeout cycle still counts as success.
  assign timeout = in_wait && !rsp_valid && (to_cnt == TO_LAST);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    st_cnt_n   = st_cnt;
    poll_cnt_n = (poll_cnt == POLL_LAST) ? poll_cnt : poll_cnt + 1'b1;
    to_cnt_n   = (in_wait && !rsp_valid) ? to_cnt + 1'b1 : '0;
    ready_n    = ready;
    joya_n     = joya;
    joyb_n     = joyb;
    err_n      = err_count;
    case (state)
      ST_STARTUP: begin
        poll_cnt_n = '0;
        if (st_cnt == ST_LAST) begin
          st_cnt_n = '0;
          idx_n    = 3'd0;
          state_n  = ST_CFG_REQ;
        end else begin
          st_cnt_n = st_cnt + 1'b1;
        end
      end
      ST_CFG_REQ: begin
        poll_cnt_n = '0;
        if (accept) state_n = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        poll_cnt_n = '0;
        if (rsp_valid) begin
          if (idx == CFG_LAST) begin
            state_n = ST_POLL_IDLE;
            ready_n = 1'b1;
          end else begin
            idx_n   = idx + 3'd1;
            state_n = ST_CFG_REQ;
          end
        end
      end
      ST_POLL_IDLE: begin
        if (!inta_sync || (poll_cnt == POLL_LAST)) begin
          state_n    = ST_RDA_REQ;
          poll_cnt_n = '0;
        end
      end
      ST_RDA_REQ: if (accept) state_n = ST_RDA_WAIT;
      ST_RDA_WAIT: begin
        if (rsp_valid) begin
          joya_n  = rsp_rdata;
          state_n = ST_RDB_REQ;
        end
      end
      ST_RDB_REQ: if (accept) state_n = ST_RDB_WAIT;
      ST_RDB_WAIT: begin
        if (rsp_valid) begin
          joyb_n  = rsp_rdata;
          state_n = ST_POLL_IDLE;
        end
      end
      default: state_n = ST_STARTUP;
    endcase
    // Recovery re-runs the whole configuration; joystick bytes are kept.
    if (timeout) begin
      state_n  = ST_STARTUP;
      st_cnt_n = '0;
      idx_n    = 3'd0;
      to_cnt_n = '0;
      ready_n  = 1'b0;
      if (err_count != 8'hFF) err_n = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_STARTUP;
      idx       <= 3'd0;
      st_cnt    <= '0;
      poll_cnt  <= '0;
      to_cnt    <= '0;
      ready     <= 1'b0;
      joya      <= 8'hFF;
      joyb      <= 8'hFF;
      err_count <= 8'h00;
      inta_meta <= 1'b1;
      inta_sync <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      st_cnt    <= st_cnt_n;
      poll_cnt  <= poll_cnt_n;
      to_cnt    <= to_cnt_n;
      ready     <= ready_n;
      joya      <= joya_n;
      joyb      <= joyb_n;
      err_count <= err_n;
      inta_meta <= inta;
      inta_sync <= inta_meta;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcp23s17_poll_sequencer.sv
`default_nettype none
// Directed bench for mcp23s17_poll_sequencer with a small SPI-engine/device model.
// Log cycle stamps are taken on the falling edge just before the accepting rising edge.
module tb_mcp23s17_poll_sequencer;
  localparam int STARTUP_CYC = 20;
  localparam int POLL_CYC    = 300;
  localparam int TIMEOUT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inta = 1'b1;
  logic       txn_valid;
  logic       txn_ready = 1'b1;
  logic [7:0] txn_opcode, txn_reg, txn_wdata;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_rdata = 8'h00;
  logic       ready;
  logic [7:0] joya, joyb, err_count;

  always #5 clk = ~clk;

  mcp23s17_poll_sequencer #(
    .HW_ADDR    (3'b000),
    .STARTUP_CYC(STARTUP_CYC),
    .POLL_CYC   (POLL_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inta      (inta),
    .txn_valid (txn_valid),
    .txn_ready (txn_ready),
    .txn_opcode(txn_opcode),
    .txn_reg   (txn_reg),
    .txn_wdata (txn_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ready     (ready),
    .joya      (joya),
    .joyb      (joyb),
    .err_count (err_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] log_q[$];
  int          log_cyc[$];
  logic [7:0]  rd_q[$];
  int          cd = 0;
  int          stall_left = 50;
  int          stall_viol = 0;
  int          last_rsp_cyc = 0;
  logic        drop13 = 1'b0;
  logic        spur = 1'b0;
  logic [7:0]  pend = 8'h00;
  logic [23:0] cfg_exp [7] = '{24'h400A40, 24'h4000FF, 24'h4001FF, 24'h400CFF,
                               24'h400DFF, 24'h4004FF, 24'h4005FF};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] lg(input int i);
    return (i < log_q.size()) ? log_q[i] : 24'hEEEEEE;
  endfunction

  function automatic int lc(input int i);
    return (i < log_cyc.size()) ? log_cyc[i] : -100000;
  endfunction

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(posedge clk); #1; k++; end
    if (log_q.size() < n) check_eq(tag, log_q.size(), n);
  endtask

  task automatic wait_ready(input logic val, input int budget, input string tag, output int at);
    int k = 0;
    while (ready !== val && k < budget) begin @(posedge clk); #1; k++; end
    at = cyc;
    if (ready !== val) check_eq(tag, 32'(ready), 32'(val));
  endtask

  // Engine + device model: 4-cycle response, GPIOA read clears INTA, optional stall/drop.
  always @(negedge clk) begin
    if (!rst_n) begin
      cd = 0; rsp_valid = 1'b0; rsp_rdata = 8'h00; txn_ready = 1'b1;
    end else begin
      rsp_valid = 1'b0; rsp_rdata = 8'h00;
      if (spur) begin rsp_valid = 1'b1; spur = 1'b0; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin rsp_valid = 1'b1; rsp_rdata = pend; last_rsp_cyc = cyc; end
      end
      if (txn_valid && log_q.size() == 3 && stall_left > 0) begin
        txn_ready = 1'b0;
        stall_left--;
        if ({txn_opcode, txn_reg, txn_wdata} != cfg_exp[3]) stall_viol++;
      end else begin
        txn_ready = 1'b1;
      end
      if (txn_valid && txn_ready) begin
        log_q.push_back({txn_opcode, txn_reg, txn_wdata});
        log_cyc.push_back(cyc);
        pend = 8'h00;
        if (txn_opcode[0] && txn_reg == 8'h12) inta = 1'b1;
        if (!(drop13 && txn_reg == 8'h13)) begin
          cd = 4;
          if (txn_opcode[0] && rd_q.size() > 0) pend = rd_q.pop_front();
        end
      end
    end
  end

  initial begin
    int n, t, t_fall;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txn_valid", txn_valid, 0);
    check_eq("rst_opcode", txn_opcode, 8'h00);
    check_eq("rst_reg", txn_reg, 8'h00);
    check_eq("rst_wdata", txn_wdata, 8'h00);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_joya", joya, 8'hFF);
    check_eq("rst_joyb", joyb, 8'hFF);
    check_eq("rst_err", err_count, 8'h00);

    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (!txn_valid && n < STARTUP_CYC + 50) begin @(posedge clk); #1; n++; end
    check_eq("startup_delay", n, STARTUP_CYC);

    wait_ready(1'b1, 2000, "cfg_ready_timeout", t);
    check_eq("cfg_count", log_q.size(), 7);
    for (int i = 0; i < 7; i++) check_eq($sformatf("cfg_entry%0d", i), lg(i), cfg_exp[i]);
    check_eq("ready_after_last_rsp", t - last_rsp_cyc, 1);
    check_eq("stall_consumed", stall_left, 0);
    check_eq("stall_stable", stall_viol, 0);

    // INTA-driven read pair
    rd_q.push_back(8'hFE); rd_q.push_back(8'h7F);
    @(negedge clk); inta = 1'b0;
    wait_log(9, 100, "inta_pair_timeout");
    repeat (10) @(posedge clk);
    #1;
    check_eq("inta_rda", lg(7), 24'h411200);
    check_eq("inta_rdb", lg(8), 24'h411300);
    check_eq("inta_joya", joya, 8'hFE);
    check_eq("inta_joyb", joyb, 8'h7F);
    spur = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("spurious_rsp_joya", joya, 8'hFE);
    check_eq("spurious_rsp_joyb", joyb, 8'h7F);
    repeat (POLL_CYC - 60) @(posedge clk);
    #1;
    check_eq("no_extra_read", log_q.size(), 9);

    // Periodic polling with INTA idle
    rd_q.push_back(8'h5A); rd_q.push_back(8'hA5);
    rd_q.push_back(8'h3C); rd_q.push_back(8'hC3);
    wait_log(11, POLL_CYC + 100, "poll1_timeout");
    repeat (10) @(posedge clk);
    #1;
    check_eq("poll1_joya", joya, 8'h5A);
    check_eq("poll1_joyb", joyb, 8'hA5);
    check_eq("poll1_period", lc(9) - lc(7), POLL_CYC);
    wait_log(13, POLL_CYC + 100, "poll2_timeout");
    repeat (10) @(posedge clk);
    #1;
    check_eq("poll2_rda", lg(11), 24'h411200);
    check_eq("poll2_rdb", lg(12), 24'h411300);
    check_eq("poll2_joya", joya, 8'h3C);
    check_eq("poll2_joyb", joyb, 8'hC3);
    check_eq("poll2_period", lc(11) - lc(9), POLL_CYC);

    // Timeout on GPIOB read, then full reconfiguration
    rd_q.push_back(8'h11);
    drop13 = 1'b1;
    wait_log(15, POLL_CYC + 100, "to_pair_timeout");
    wait_ready(1'b0, TIMEOUT_CYC + 100, "to_ready_fall_timeout", t_fall);
    check_eq("to_latency", t_fall - lc(14), TIMEOUT_CYC + 1);
    check_eq("to_err_count", err_count, 8'h01);
    check_eq("to_joya_kept", joya, 8'h11);
    check_eq("to_joyb_kept", joyb, 8'hC3);
    drop13 = 1'b0;
    wait_log(16, STARTUP_CYC + 100, "recfg_start_timeout");
    check_eq("recfg_delay", lc(15) - t_fall, STARTUP_CYC);
    check_eq("recfg_first", lg(15), cfg_exp[0]);

    // Asynchronous reset while in CFG_WAIT
    wait_log(18, 500, "recfg_idx2_timeout");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("areset_joya", joya, 8'hFF);
    check_eq("areset_joyb", joyb, 8'hFF);
    check_eq("areset_err", err_count, 8'h00);
    check_eq("areset_ready", ready, 0);
    check_eq("areset_txn_valid", txn_valid, 0);
    check_eq("areset_opcode", txn_opcode, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (!txn_valid && n < STARTUP_CYC + 50) begin @(posedge clk); #1; n++; end
    check_eq("areset_startup_delay", n, STARTUP_CYC);
    check_eq("areset_first_reg", {txn_opcode, txn_reg, txn_wdata}, cfg_exp[0]);
    wait_ready(1'b1, 2000, "areset_ready_timeout", t);
    check_eq("areset_cfg_count", log_q.size(), 25);
    check_eq("areset_cfg_last", lg(24), cfg_exp[6]);
    check_eq("areset_err_after", err_count, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
